// File: rtl/hc_alarm_pkg.sv
// Shared types and constants for the healthcare alarm transmitter.
// Optional feature macro: HC_ALARM_PARITY_EN (adds an even-parity bit after the data byte).
package hc_alarm_pkg;

  // Transmit FSM states; ST_PARITY is only visited when parity is enabled.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Alarm codes double as the index of the flag inside the pending vector.
  localparam logic [1:0] CODE_FALL  = 2'b00;
  localparam logic [1:0] CODE_PRESS = 2'b01;
  localparam logic [1:0] CODE_TEMP  = 2'b10;
  localparam logic [1:0] CODE_BLOOD = 2'b11;

  // Fixed upper bits of every transmitted byte.
  localparam logic [2:0] HDR = 3'b101;

  // One-hot pending-bit mask for an alarm code.
  function automatic logic [3:0] code_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/hc_alarm_pending.sv
// Edge detector, pending-event register and priority encoder for the alarm flags.
// Flag vector order is {blood, temp, pressure, fall}; bit index equals alarm code.
// Behaviour is identical with or without HC_ALARM_PARITY_EN.
module hc_alarm_pending
  import hc_alarm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flags,
  input  logic [3:0] clear_onehot,
  output logic [3:0] pending,
  output logic       valid,
  output logic [1:0] code
);

  logic [3:0] prev;

  // Queue rising edges; a new edge on the bit being cleared keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      prev    <= flags;
      pending <= (pending & ~clear_onehot) | (flags & ~prev);
    end
  end

  // Fixed priority: fall > pressure > temperature > blood.
  always_comb begin
    valid = |pending;
    code  = CODE_BLOOD;
    if (pending[CODE_FALL])       code = CODE_FALL;
    else if (pending[CODE_PRESS]) code = CODE_PRESS;
    else if (pending[CODE_TEMP])  code = CODE_TEMP;
  end

endmodule

// File: rtl/healthcare_alarm_pending.sv
// Pending-event logic for the alarm transmitter is implemented in hc_alarm_pending.sv.

// File: rtl/healthcare_alarm_transmitter.sv
// Serialises queued alarm events into UART-style frames for the nurse station.
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1).
// Define HC_ALARM_PARITY_EN to insert the parity bit (11-bit frames instead of 10).
module healthcare_alarm_transmitter
  import hc_alarm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       fallDetected,
  input  logic       temperatureAbnormality,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic [3:0] pending,
  output logic       frame_sent
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [2:0]       seq;
  logic             alarm_valid;
  logic [1:0]       alarm_code;
  logic [3:0]       flags;
  logic [3:0]       clear_onehot;
`ifdef HC_ALARM_PARITY_EN
  logic             parity;
`endif

  assign flags = {bloodAbnormality, temperatureAbnormality, presureAbnormality, fallDetected};

  // The chosen event is dequeued on the same edge its frame is loaded.
  assign clear_onehot = (state == ST_IDLE && alarm_valid) ? code_onehot(alarm_code) : 4'b0000;

  hc_alarm_pending u_pending (
    .clk          (clk),
    .rst          (rst),
    .flags        (flags),
    .clear_onehot (clear_onehot),
    .pending      (pending),
    .valid        (alarm_valid),
    .code         (alarm_code)
  );

  // Frame FSM with bit-time counter; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      frame_sent <= 1'b0;
      seq        <= 3'd0;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
`ifdef HC_ALARM_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      frame_sent <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alarm_valid) begin
            state     <= ST_START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
            shift     <= {HDR, seq, alarm_code};
            cnt       <= '0;
`ifdef HC_ALARM_PARITY_EN
            parity    <= ^{HDR, seq, alarm_code};
`endif
          end
        end
        ST_START: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            state     <= ST_DATA;
            tx_serial <= shift[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef HC_ALARM_PARITY_EN
              state     <= ST_PARITY;
              tx_serial <= parity;
`else
              state     <= ST_STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift     <= shift >> 1;
              tx_serial <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef HC_ALARM_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= ST_STOP;
            tx_serial <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
            seq     <= seq + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Raise the pulse so it is visible during the final stop-bit cycle.
            if (cnt == CNT_PRE) frame_sent <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_healthcare_alarm_transmitter.sv
// Self-checking bench for healthcare_alarm_transmitter (CLKS_PER_BIT=16).
// Honours HC_ALARM_PARITY_EN when the design is built with it.
module tb_healthcare_alarm_transmitter;

  localparam int CPB = 16;
`ifdef HC_ALARM_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hold_flags = 4'b0000;
  logic [3:0] inj_flags  = 4'b0000;
  logic [3:0] flags;
  logic       tx_serial, tx_busy, frame_sent;
  logic [3:0] pending;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] seq_m    = 3'd0;

  assign flags = hold_flags | inj_flags;

  always #5 clk = ~clk;

  healthcare_alarm_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .presureAbnormality     (flags[1]),
    .bloodAbnormality       (flags[3]),
    .fallDetected           (flags[0]),
    .temperatureAbnormality (flags[2]),
    .tx_serial              (tx_serial),
    .tx_busy                (tx_busy),
    .pending                (pending),
    .frame_sent             (frame_sent)
  );

  // Highest-priority queued event: lowest set index (fall=0 ... blood=3).
  function automatic logic [1:0] top_code(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Expected line level on frame cycle c (1-based) for byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    int idx;
    idx = (c - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NBITS == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Check one whole frame beginning on the next sample, plus the idle gap after it.
  task automatic expect_frame(input logic [1:0] code, input logic [3:0] exp_pend, input string name);
    logic [7:0] b;
    int         bad_c;
    logic       bad_tx, bad_busy, bad_fs;
    b = {3'b101, seq_m, code};
    bad_c = 0; bad_tx = 1'b0; bad_busy = 1'b0; bad_fs = 1'b0;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (pending !== exp_pend) begin
          failures++;
          $display("FAIL %s pending_after_load: got %b expected %b", name, pending, exp_pend);
        end
      end
      if (bad_c == 0 && (tx_serial !== exp_bit(b, c) || tx_busy !== 1'b1 ||
                         frame_sent !== (c == FRAME_CYC))) begin
        bad_c = c; bad_tx = tx_serial; bad_busy = tx_busy; bad_fs = frame_sent;
      end
    end
    checks++;
    if (bad_c != 0) begin
      failures++;
      $display("FAIL %s frame_wave byte %02h cycle %0d: got tx=%b busy=%b sent=%b expected tx=%b busy=1 sent=%b",
               name, b, bad_c, bad_tx, bad_busy, bad_fs, exp_bit(b, bad_c), (bad_c == FRAME_CYC));
    end
    @(negedge clk);
    checks++;
    if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || frame_sent !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_gap: got tx=%b busy=%b sent=%b expected tx=1 busy=0 sent=0",
               name, tx_serial, tx_busy, frame_sent);
    end
    $display("frame %s byte=%02h seq=%0d code=%0d", name, b, seq_m, code);
    seq_m = seq_m + 3'd1;
  endtask

  // Raise flags at a negedge; one edge later the events are queued but the line is still idle.
  task automatic raise(input logic [3:0] mask, input string name);
    hold_flags = mask;
    @(negedge clk);
    checks++;
    if (pending !== mask || tx_serial !== 1'b1) begin
      failures++;
      $display("FAIL %s queue_latency: got pending=%b tx=%b expected pending=%b tx=1",
               name, pending, tx_serial, mask);
    end
  endtask

  // Expect back-to-back frames draining `mask`; `late` joins the queue during the first frame.
  task automatic run_sequence(input logic [3:0] mask, input logic [3:0] late, input string name);
    logic [3:0] pend;
    logic [1:0] c;
    bit         first;
    pend = mask;
    first = 1'b1;
    while (pend != 4'b0000) begin
      c = top_code(pend);
      pend[c] = 1'b0;
      expect_frame(c, pend, name);
      if (first) pend = pend | late;
      first = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    hold_flags = 4'b1111;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || pending !== 4'b0000 || frame_sent !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cycle %0d: got tx=%b busy=%b pending=%b sent=%b expected 1 0 0000 0",
                 i, tx_serial, tx_busy, pending, frame_sent);
      end
    end
    rst = 1'b0;
    seq_m = 3'd0;
    @(negedge clk);
    checks++;
    if (pending !== 4'b1111 || tx_serial !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_edges: got pending=%b tx=%b expected 1111 1", pending, tx_serial);
    end
    run_sequence(4'b1111, 4'b0000, "reset_release");
    hold_flags = 4'b0000;
    idle_cycles(2);
  endtask

  task automatic test_single();
    raise(4'b0001, "single");
    hold_flags = 4'b0000;
    run_sequence(4'b0001, 4'b0000, "single");
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    raise(4'b1111, "all_four");
    run_sequence(4'b1111, 4'b0000, "all_four");
    hold_flags = 4'b0000;
    idle_cycles(2);
  endtask

  task automatic test_level_vs_edge();
    bit quiet;
    raise(4'b0001, "level");
    run_sequence(4'b0001, 4'b0000, "level");
    quiet = 1'b1;
    repeat (1000 - FRAME_CYC - 2) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || pending !== 4'b0000) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL level_no_refire: got activity while flag held expected idle line");
    end
    hold_flags = 4'b0000;
    idle_cycles(3);
    raise(4'b0001, "reraise");
    hold_flags = 4'b0000;
    run_sequence(4'b0001, 4'b0000, "reraise");
    idle_cycles(2);
  endtask

  task automatic test_seq_wrap();
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    seq_m = 3'd0;
    idle_cycles(1);
    for (int k = 0; k < 9; k++) begin
      raise(4'b0001, "wrap");
      hold_flags = 4'b0000;
      run_sequence(4'b0001, 4'b0000, "wrap");
      idle_cycles(1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit quiet;
    raise(4'b1111, "mid_reset");
    hold_flags = 4'b0000;
    idle_cycles(70);              // frame cycle 70 lies inside data bit 3
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || pending !== 4'b0000 || frame_sent !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: got tx=%b busy=%b pending=%b sent=%b expected 1 0 0000 0",
               tx_serial, tx_busy, pending, frame_sent);
    end
    rst = 1'b0;
    seq_m = 3'd0;
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || frame_sent !== 1'b0 || pending !== 4'b0000) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL mid_reset_abandon: got line activity or frame_sent after reset expected idle");
    end
    raise(4'b0001, "post_reset");
    hold_flags = 4'b0000;
    run_sequence(4'b0001, 4'b0000, "post_reset");
    idle_cycles(2);
  endtask

  // Random flag subsets, random hold lengths, and a random new edge arriving mid-frame.
  task automatic test_random();
    logic [3:0] m, injm;
    int         h, d, sel;
    for (int r = 0; r < 8; r++) begin
      m    = 4'($urandom_range(1, 15));
      sel  = $urandom_range(0, 3);
      injm = ~m & (4'b0001 << sel);
      if ($urandom_range(0, 1) == 0) injm = 4'b0000;
      h = $urandom_range(1, 150);
      d = $urandom_range(5, 140);
      raise(m, "random");
      fork
        begin
          automatic int hh = h;
          repeat (hh) @(negedge clk);
          hold_flags = 4'b0000;
        end
        begin
          automatic int dd = d;
          automatic logic [3:0] im = injm;
          repeat (dd) @(negedge clk);
          inj_flags = im;
          @(negedge clk);
          inj_flags = 4'b0000;
        end
      join_none
      run_sequence(m, injm, "random");
      idle_cycles(3);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_level_vs_edge();
    test_seq_wrap();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
